// File: rtl/sum_latch_uart_tx_if.sv
// Pin-side bundle of the sum/latch UART block: operand strobes and bus in,
// transmit request in, serial line, busy flag and running sum out.
interface sum_latch_uart_tx_if #(
  parameter int DATA_W  = 4,
  parameter int NUM_OPS = 2
);
  localparam int SUM_W = DATA_W + $clog2(NUM_OPS);

  logic [NUM_OPS-1:0] save_n;
  logic [DATA_W-1:0]  data_in;
  logic               uart_tx_en;
  logic               uart_busy;
  logic               uart_txd;
  logic [SUM_W-1:0]   sum_out;

  modport master (
    output save_n, data_in, uart_tx_en,
    input  uart_busy, uart_txd, sum_out
  );

  modport slave (
    input  save_n, data_in, uart_tx_en,
    output uart_busy, uart_txd, sum_out
  );
endinterface

// File: rtl/sum_latch_uart_tx.sv
// Captures NUM_OPS operands from asynchronous strobes, keeps their registered sum and
// sends a snapshot of it LSB byte first over a UART. Define PARITY_EN for 8E1 instead of 8N1.
module sum_latch_uart_tx #(
  parameter int DATA_W       = 4,
  parameter int NUM_OPS      = 2,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic              clk,
  input  logic              reset,
  sum_latch_uart_tx_if.slave bus
);
  localparam int SUM_W     = DATA_W + $clog2(NUM_OPS);
  localparam int NUM_BYTES = (SUM_W + 7) / 8;
  localparam int SHIFT_W   = NUM_BYTES * 8;
  localparam int CNT_W     = $clog2(CLKS_PER_BIT);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [NUM_OPS-1:0] r_save_s1, r_save_s2, r_save_prev;
  logic               r_tx_s1, r_tx_s2, r_tx_prev;
  logic [NUM_OPS-1:0] w_save_fall;
  logic               w_tx_rise;
  logic [DATA_W-1:0]  r_op [NUM_OPS];
  logic [SUM_W-1:0]   w_sum;
  logic [SUM_W-1:0]   r_sum;
  logic [2:0]         r_state;
  logic [CNT_W-1:0]   r_clk_cnt;
  logic [2:0]         r_bit_cnt;
  logic [1:0]         r_byte_cnt;
  logic [SHIFT_W-1:0] r_shift;
  logic               r_busy;
  logic               r_txd;
`ifdef PARITY_EN
  logic               r_parity;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would make the synchroniser stages collapse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_save_s1   <= '1;
      r_save_s2   <= '1;
      r_save_prev <= '1;
      r_tx_s1     <= 1'b0;
      r_tx_s2     <= 1'b0;
      r_tx_prev   <= 1'b0;
    end else begin
      r_save_s1   <= bus.save_n;
      r_save_s2   <= r_save_s1;
      r_save_prev <= r_save_s2;
      r_tx_s1     <= bus.uart_tx_en;
      r_tx_s2     <= r_tx_s1;
      r_tx_prev   <= r_tx_s2;
    end
  end

  assign w_save_fall = r_save_prev & ~r_save_s2;
  assign w_tx_rise   = r_tx_s2 & ~r_tx_prev;

  // NOTE: the operand array is architectural state with a defined reset value, so it
  // is reset element by element rather than left as an unreset memory.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_OPS; i++) r_op[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_OPS; i++)
        if (w_save_fall[i]) r_op[i] <= bus.data_in;
    end
  end

  // NOTE: w_sum is assigned before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NUM_OPS; i++) w_sum = w_sum + SUM_W'(r_op[i]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sum <= '0;
    else       r_sum <= w_sum;
  end

  // Snapshot reads r_sum, so a save landing in the same cycle only shows up next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_clk_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
      r_shift    <= '0;
      r_busy     <= 1'b0;
      r_txd      <= 1'b1;
`ifdef PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_tx_rise) begin
            r_shift    <= SHIFT_W'(r_sum);
            r_state    <= S_START;
            r_busy     <= 1'b1;
            r_txd      <= 1'b0;
            r_clk_cnt  <= '0;
            r_byte_cnt <= '0;
          end
        end
        S_START: begin
          if (r_clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_state   <= S_DATA;
            r_txd     <= r_shift[0];
`ifdef PARITY_EN
            r_parity  <= r_shift[0];
`endif
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
            r_clk_cnt <= '0;
            r_shift   <= r_shift >> 1;
            if (r_bit_cnt == 3'd7) begin
`ifdef PARITY_EN
              r_state <= S_PARITY;
              r_txd   <= r_parity;
`else
              r_state <= S_STOP;
              r_txd   <= 1'b1;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_txd     <= r_shift[1];
`ifdef PARITY_EN
              r_parity  <= r_parity ^ r_shift[1];
`endif
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
`ifdef PARITY_EN
        S_PARITY: begin
          if (r_clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
            r_clk_cnt <= '0;
            r_state   <= S_STOP;
            r_txd     <= 1'b1;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (r_clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
            r_clk_cnt <= '0;
            if (r_byte_cnt == 2'(NUM_BYTES - 1)) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_txd   <= 1'b1;
            end else begin
              r_byte_cnt <= r_byte_cnt + 1'b1;
              r_state    <= S_START;
              r_txd      <= 1'b0;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_txd   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.sum_out   = r_sum;
  assign bus.uart_busy = r_busy;
  assign bus.uart_txd  = r_txd;
endmodule
